// File: rtl/fetch_instr_queue.sv
// In-order instruction FIFO between fetch and decode; cleared on pipeline redirect.
// Optional same-cycle bypass on an empty queue: define FETCH_INSTR_QUEUE_BYPASS_EN.
module fetch_instr_queue #(
    parameter int DEPTH            = 4,
    parameter int PC_WIDTH         = 64,
    parameter int INST_WIDTH       = 32,
    parameter int XCPT_CAUSE_WIDTH = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        push_valid_i,
    output logic                        push_ready_o,
    input  logic [PC_WIDTH-1:0]         push_pc_i,
    input  logic [INST_WIDTH-1:0]       push_inst_i,
    input  logic                        push_bpred_taken_i,
    input  logic [PC_WIDTH-1:0]         push_bpred_addr_i,
    input  logic                        push_xcpt_valid_i,
    input  logic [XCPT_CAUSE_WIDTH-1:0] push_xcpt_cause_i,
    output logic                        pop_valid_o,
    input  logic                        pop_ready_i,
    output logic [PC_WIDTH-1:0]         pop_pc_o,
    output logic [INST_WIDTH-1:0]       pop_inst_o,
    output logic                        pop_bpred_taken_o,
    output logic [PC_WIDTH-1:0]         pop_bpred_addr_o,
    output logic                        pop_xcpt_valid_o,
    output logic [XCPT_CAUSE_WIDTH-1:0] pop_xcpt_cause_o,
    output logic [$clog2(DEPTH):0]      count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_WIDTH-1:0]         pc_mem    [DEPTH];
    logic [INST_WIDTH-1:0]       inst_mem  [DEPTH];
    logic                        taken_mem [DEPTH];
    logic [PC_WIDTH-1:0]         addr_mem  [DEPTH];
    logic                        xv_mem    [DEPTH];
    logic [XCPT_CAUSE_WIDTH-1:0] cause_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic empty, full, bypass, push_fire, pop_fire;

    always_comb begin
        empty  = (count_q == '0);
        full   = (count_q == CNT_W'(DEPTH));
        bypass = 1'b0;
`ifdef FETCH_INSTR_QUEUE_BYPASS_EN
        bypass = empty & push_valid_i & ~flush_i;
`endif
        push_ready_o = ~full;
        pop_valid_o  = ~empty | bypass;
        // A bypassed entry taken by decode in the same cycle is never stored.
        push_fire = push_valid_i & ~full & ~flush_i & ~(bypass & pop_ready_i);
        pop_fire  = ~empty & pop_ready_i & ~flush_i;
    end

    always_comb begin
        pop_pc_o          = '0;
        pop_inst_o        = '0;
        pop_bpred_taken_o = 1'b0;
        pop_bpred_addr_o  = '0;
        pop_xcpt_valid_o  = 1'b0;
        pop_xcpt_cause_o  = '0;
        if (bypass) begin
            pop_pc_o          = push_pc_i;
            pop_inst_o        = push_inst_i;
            pop_bpred_taken_o = push_bpred_taken_i;
            pop_bpred_addr_o  = push_bpred_addr_i;
            pop_xcpt_valid_o  = push_xcpt_valid_i;
            pop_xcpt_cause_o  = push_xcpt_cause_i;
        end else if (!empty) begin
            pop_pc_o          = pc_mem[rd_ptr_q];
            pop_inst_o        = inst_mem[rd_ptr_q];
            pop_bpred_taken_o = taken_mem[rd_ptr_q];
            pop_bpred_addr_o  = addr_mem[rd_ptr_q];
            pop_xcpt_valid_o  = xv_mem[rd_ptr_q];
            pop_xcpt_cause_o  = cause_mem[rd_ptr_q];
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_fire)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_fire, pop_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (push_fire && !rst_i) begin
            pc_mem[wr_ptr_q]    <= push_pc_i;
            inst_mem[wr_ptr_q]  <= push_inst_i;
            taken_mem[wr_ptr_q] <= push_bpred_taken_i;
            addr_mem[wr_ptr_q]  <= push_bpred_addr_i;
            xv_mem[wr_ptr_q]    <= push_xcpt_valid_i;
            cause_mem[wr_ptr_q] <= push_xcpt_cause_i;
        end
    end

    assign count_o = count_q;

endmodule
